v_rr_mqueue: RTL and testbench
==============================

# v_rr_mqueue

Parametrised multi-channel input queue with round-robin output arbitration. It accepts N independent valid/ready streams, buffers each in its own D-entry FIFO, and merges them onto a single valid/ready output tagged with the source channel. It is the general ingress merge stage ahead of shared pipelines in `v`. It supersedes single-channel fixed-size skid buffers.

## Interface
Parameters:
- `W`, 32: payload width in bits, at least 1.
- `N`, 4: channel count, at least 2.
- `D`, 4: entries per channel FIFO, a power of two and at least 2.

Ports:
- `clk`  in  1  Sole clock; all state updates on the rising edge.
- `rst`  in  1  Reset: synchronous, active-high.
- `in_vld`  in  N  Per-channel input valid.
- `in_dat`  in  N*W  Per-channel payload; channel i occupies bits [i*W +: W].
- `in_rdy`  out  N  Per-channel input ready: its FIFO is not full.
- `out_vld`  out  1  Output valid.
- `out_dat`  out  W  Head payload of the granted channel.
- `out_ch`  out  $clog2(N)  Index of the granted channel.
- `out_rdy`  in  1  Output ready.
- `ch_cnt`  out  N*$clog2(D+1)  Per-channel occupancy; channel i in field i.

## Operation
- Each channel has a circular FIFO with a write pointer, a read pointer ($clog2(D) bits, natural wrap) and a count ($clog2(D+1) bits).
- Push on channel i when `in_vld[i] && in_rdy[i]`.
- Pop on the granted channel when `out_vld && out_rdy`.
- `in_rdy[i] = (cnt[i] != D) && !rst`. It depends only on registered state, so there is no combinational path from `out_rdy` to `in_rdy`.
- A full FIFO refuses a push even when a pop occurs in the same cycle.
- Push and pop on the same channel in the same cycle: the count is unchanged and both pointers advance.
- There is no bypass. Data written in cycle t is poppable in cycle t+1 at the earliest.
- Arbitration: a `last` register holds the last granted index and resets to N-1, so channel 0 has top priority after reset.
  - The grant goes to the first non-empty channel scanning last+1, last+2, … modulo N.
  - `last` updates to the granted index only on an output handshake.
- Grant lock: if `out_vld && !out_rdy`, a `lock` flag sets and the locked index is held.
  - While locked, `out_ch` and `out_dat` must not change, even if higher-priority channels become non-empty.
  - The lock clears on the handshake.
  - A locked channel cannot become empty, because only a pop removes data.
- `out_vld` = OR of all channels non-empty.
- When `out_vld` = 0, `out_ch` and `out_dat` are don't-care. A bench may check them only when valid.
- Reset in the middle of operation discards all buffered data. No output handshake is reported in the reset cycle.

## Timing
- Reset values, in effect from the cycle after `rst` is sampled high:
  - all counts and pointers 0, so `ch_cnt` = 0 and `out_vld` = 0;
  - `lock` = 0 and `last` = N-1;
  - `in_rdy` = all 0 while `rst` is high and all 1 in the first cycle after reset deasserts.
- Latency: input handshake at edge t, then `out_vld` can be high in cycle t+1. With `out_rdy` held at 1, throughput is one beat per cycle in aggregate.
- `out_vld`, `out_ch` and `out_dat` are combinational from registered state only. No input-to-output combinational path exists.
- `ch_cnt` reflects the count after the previous edge.
- Fairness: with all N channels continuously non-empty and `out_rdy` = 1, the grants cycle through 0, 1, …, N-1 and then repeat. Each channel is served at least once every N handshakes.
- Wrap-around: after D pushes the write pointer returns to 0. Data order is preserved across the wrap.

## Test plan
Configuration for all scenarios: W=8, N=4, D=4.
- Reset, then single channel: push 0x11, 0x22, 0x33 on channel 2 with `out_rdy`=1.
  - `out_vld` first rises one cycle after the first push.
  - The output is 0x11, 0x22, 0x33 in order, each with `out_ch`=2.
- Full: push 5 beats on channel 1 with `out_rdy`=0.
  - `in_rdy[1]` drops after 4 beats and `ch_cnt[1]`=4.
  - The 5th beat is held off.
  - When `out_rdy`=1, the 5th beat is accepted only after a pop frees an entry, and all 5 beats arrive in order.
- Round-robin: fill all 4 channels with 2 beats each (channel c holds 0xc0 and 0xc1), then set `out_rdy`=1.
  - `out_ch` sequence is 0,1,2,3,0,1,2,3.
  - `out_dat` sequence is 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31.
- Grant lock: channel 3 non-empty and channel 0 empty; set `out_rdy`=0, then push 0xAA on channel 0.
  - `out_ch` stays 3 with unchanged `out_dat` until `out_rdy`=1.
  - The next grant is channel 0 with 0xAA.
- Wrap and concurrency: on one channel, push and pop every cycle for 10 cycles.
  - The count stays constant and the pointers wrap past D.
  - The data sequence is exact with no loss or duplication.
- Reset mid-stream: assert `rst` for 1 cycle with 3 channels partly full.
  - The next cycle shows `ch_cnt`=0, `out_vld`=0 and `in_rdy`=0.
  - The cycle after shows `in_rdy`=0xF.
  - The first subsequent grant after pushes on channels 1 and 0 is channel 0.

Source files
------------

// File: rtl/v_rr_mqueue.sv
// N-channel ingress merge: one circular FIFO per channel,
// round-robin output grant with a hold-while-stalled lock.
module v_rr_mqueue #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int D = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 in_vld,
  input  logic [N*W-1:0]               in_dat,
  output logic [N-1:0]                 in_rdy,
  output logic                         out_vld,
  output logic [W-1:0]                 out_dat,
  output logic [$clog2(N)-1:0]         out_ch,
  input  logic                         out_rdy,
  output logic [N*$clog2(D+1)-1:0]     ch_cnt
);

  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D+1);
  localparam int NW = $clog2(N);

  logic [W-1:0]  mem [N][D];
  logic [AW-1:0] wp  [N];
  logic [AW-1:0] rp  [N];
  logic [CW-1:0] cnt [N];

  logic [N-1:0]  nempty;
  logic [N-1:0]  push;
  logic [N-1:0]  popv;
  logic [NW-1:0] last;
  logic [NW-1:0] lock_ch;
  logic [NW-1:0] pick;
  logic [NW-1:0] gnt;
  logic          lock;
  logic          found;
  logic          pop;

  always_comb begin
    nempty = '0;
    in_rdy = '0;
    push   = '0;
    ch_cnt = '0;
    for (int i = 0; i < N; i++) begin
      nempty[i] = cnt[i] != '0;
      in_rdy[i] = (cnt[i] != CW'(D)) && !rst;
      push[i]   = in_vld[i] && in_rdy[i];
      ch_cnt[i*CW +: CW] = cnt[i];
    end
  end

  // scan last+1, last+2, ... so the previous winner goes last
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(last) + k) % N;
      if (!found && nempty[j]) begin
        found = 1'b1;
        pick  = NW'(j);
      end
    end
  end

  assign gnt     = lock ? lock_ch : pick;
  assign out_vld = |nempty;
  assign out_ch  = gnt;
  assign out_dat = mem[gnt][rp[gnt]];
  assign pop     = out_vld && out_rdy && !rst;

  always_comb begin
    popv = '0;
    for (int i = 0; i < N; i++)
      popv[i] = pop && (gnt == NW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      last    <= NW'(N-1);
      lock    <= 1'b0;
      lock_ch <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i])
          wp[i] <= wp[i] + 1'b1;
        if (popv[i])
          rp[i] <= rp[i] + 1'b1;
        if (push[i] && !popv[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!push[i] && popv[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
      if (pop) begin
        last <= gnt;
        lock <= 1'b0;
      end else if (out_vld) begin
        lock    <= 1'b1;
        lock_ch <= gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (push[i])
        mem[i][wp[i]] <= in_dat[i*W +: W];
  end

endmodule

// File: tb/tb_v_rr_mqueue.sv
// Directed bench for v_rr_mqueue (W=8, N=4, D=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_v_rr_mqueue;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_vld;
  logic [N*W-1:0] in_dat;
  logic [N-1:0]   in_rdy;
  logic           out_vld;
  logic [W-1:0]   out_dat;
  logic [1:0]     out_ch;
  logic           out_rdy;
  logic [N*CW-1:0] ch_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  v_rr_mqueue #(.W(W), .N(N), .D(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_dat  (in_dat),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_dat (out_dat),
    .out_ch  (out_ch),
    .out_rdy (out_rdy),
    .ch_cnt  (ch_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int c);
    return 32'(ch_cnt[c*CW +: CW]);
  endfunction

  task automatic stage(input int c, input logic [7:0] v);
    in_vld[c] = 1'b1;
    in_dat[c*W +: W] = v;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_vld = '0;
    out_rdy = 1'b0;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_vld = '0;
    in_dat = '0;
    out_rdy = 1'b0;
    nxt();
    nxt();
    chk("rst_in_rdy", 32'(in_rdy), 32'h0);
    chk("rst_cnt", 32'(ch_cnt), 32'h0);
    chk("rst_vld", 32'(out_vld), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_rdy", 32'(in_rdy), 32'hF);

    // single channel, latency and order
    out_rdy = 1'b1;
    stage(2, 8'h11);
    chk("s1_pre_vld", 32'(out_vld), 32'h0);
    nxt();
    chk("s1_vld", 32'(out_vld), 32'h1);
    chk("s1_ch0", 32'(out_ch), 32'h2);
    chk("s1_d0", 32'(out_dat), 32'h11);
    stage(2, 8'h22);
    nxt();
    chk("s1_ch1", 32'(out_ch), 32'h2);
    chk("s1_d1", 32'(out_dat), 32'h22);
    stage(2, 8'h33);
    nxt();
    chk("s1_ch2", 32'(out_ch), 32'h2);
    chk("s1_d2", 32'(out_dat), 32'h33);
    in_vld = '0;
    nxt();
    chk("s1_empty", 32'(out_vld), 32'h0);

    // full channel holds off the fifth beat
    out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      stage(1, 8'(8'h51 + k));
      nxt();
    end
    chk("s2_rdy_full", 32'(in_rdy[1]), 32'h0);
    chk("s2_cnt4", cnt_of(1), 32'd4);
    chk("s2_head", 32'(out_dat), 32'h51);
    stage(1, 8'h55);
    nxt();
    chk("s2_held_cnt", cnt_of(1), 32'd4);
    chk("s2_held_rdy", 32'(in_rdy[1]), 32'h0);
    out_rdy = 1'b1;
    nxt();
    chk("s2_nopush_cnt", cnt_of(1), 32'd3);
    chk("s2_d1", 32'(out_dat), 32'h52);
    chk("s2_rdy_back", 32'(in_rdy[1]), 32'h1);
    nxt();
    chk("s2_d2", 32'(out_dat), 32'h53);
    chk("s2_cnt_pp", cnt_of(1), 32'd3);
    in_vld = '0;
    nxt();
    chk("s2_d3", 32'(out_dat), 32'h54);
    nxt();
    chk("s2_d4", 32'(out_dat), 32'h55);
    chk("s2_ch", 32'(out_ch), 32'h1);
    nxt();
    chk("s2_empty", 32'(out_vld), 32'h0);
    chk("s2_cnt0", cnt_of(1), 32'd0);

    // round robin across all channels
    do_reset();
    for (int c = 0; c < N; c++) stage(c, 8'(c << 4));
    nxt();
    for (int c = 0; c < N; c++) stage(c, 8'((c << 4) | 1));
    nxt();
    in_vld = '0;
    chk("s3_cnts", 32'(ch_cnt), 32'h492);
    out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s3_ch%0d", k), 32'(out_ch), 32'(k % 4));
      chk($sformatf("s3_d%0d", k), 32'(out_dat),
          32'(((k % 4) << 4) | (k / 4)));
      nxt();
    end
    chk("s3_empty", 32'(out_vld), 32'h0);

    // grant lock while stalled
    do_reset();
    stage(3, 8'h3C);
    nxt();
    in_vld = '0;
    chk("s4_ch_a", 32'(out_ch), 32'h3);
    stage(0, 8'hAA);
    nxt();
    in_vld = '0;
    chk("s4_lock_ch_b", 32'(out_ch), 32'h3);
    chk("s4_lock_d_b", 32'(out_dat), 32'h3C);
    nxt();
    chk("s4_lock_ch_c", 32'(out_ch), 32'h3);
    chk("s4_lock_d_c", 32'(out_dat), 32'h3C);
    out_rdy = 1'b1;
    nxt();
    chk("s4_next_ch", 32'(out_ch), 32'h0);
    chk("s4_next_d", 32'(out_dat), 32'hAA);
    nxt();
    chk("s4_empty", 32'(out_vld), 32'h0);

    // concurrent push/pop with pointer wrap
    do_reset();
    stage(1, 8'h60);
    nxt();
    stage(1, 8'h61);
    nxt();
    out_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("s5_d%0d", k), 32'(out_dat), 32'(8'h60 + k));
      chk($sformatf("s5_cnt%0d", k), cnt_of(1), 32'd2);
      stage(1, 8'(8'h62 + k));
      nxt();
    end
    in_vld = '0;
    chk("s5_tail0", 32'(out_dat), 32'h6A);
    nxt();
    chk("s5_tail1", 32'(out_dat), 32'h6B);
    nxt();
    chk("s5_empty", 32'(out_vld), 32'h0);

    // reset mid-stream
    out_rdy = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) stage(c, 8'(8'h70 + c));
      nxt();
    end
    in_vld = '0;
    chk("s6_prefill", 32'(ch_cnt), 32'h092);
    rst = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("s6_cnt0", 32'(ch_cnt), 32'h0);
    chk("s6_vld0", 32'(out_vld), 32'h0);
    chk("s6_rdy0", 32'(in_rdy), 32'h0);
    nxt();
    rst = 1'b0;
    out_rdy = 1'b0;
    #1;
    chk("s6_rdyF", 32'(in_rdy), 32'hF);
    stage(1, 8'h81);
    stage(0, 8'h80);
    nxt();
    in_vld = '0;
    chk("s6_gnt_ch", 32'(out_ch), 32'h0);
    chk("s6_gnt_d", 32'(out_dat), 32'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
